fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain stage for the synchronous FIFO. It pops words from the FIFO's registered read port and presents them as a valid/ready stream. A small internal elastic buffer absorbs the FIFO's one-cycle read latency and downstream back-pressure, so sustained throughput is one word per clock. It sits directly downstream of the FIFO, driving its read enable and consuming its data output and empty flag.

## Interface
- WIDTH, 4, data word width; must equal the FIFO's width.
- BUF_DEPTH, 3, internal elastic buffer entries; minimum 3 for full throughput.
- CNT_W, 16, width of the delivered-word counter.

- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  WIDTH  FIFO data out; valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  FIFO read enable.
- m_data  output  WIDTH  stream data.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream accept.
- word_cnt  output  CNT_W  count of completed m_valid&&m_ready handshakes.

## Operation
- State:
  - buffer entries, written and read in FIFO order;
  - count, 0..BUF_DEPTH;
  - inflight, 1 bit, meaning a read was issued last cycle;
  - word_cnt.
- fifo_rd_en = !rst && !fifo_empty && (count + inflight < BUF_DEPTH).
  - Driven only from registered state and fifo_empty; there is no combinational path from m_ready.
- inflight <= fifo_rd_en each cycle.
- Push: when inflight is 1, fifo_data is written at the buffer tail.
- Pop: when m_valid && m_ready, the buffer head is retired.
- Push and pop in the same cycle: count is unchanged and the head advances.
- m_valid = (count != 0). m_data is the buffer head.
- m_data and m_valid hold stable while m_valid && !m_ready.
- word_cnt increments by 1 on each handshake and wraps from 2^CNT_W-1 to 0.
- Overflow cannot occur: the credit check guarantees count + inflight never exceeds BUF_DEPTH.
- No state machine beyond the count and inflight registers; the block is a pure credit-managed buffer.

## Timing
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, word_cnt=0, count=0, inflight=0.
- Latency from FIFO to stream:
  - fifo_empty low in cycle N with credit available gives fifo_rd_en=1 in cycle N;
  - the word is captured at the end of N+1;
  - m_valid=1 in N+2.
- Steady state with m_ready held at 1 and the FIFO non-empty: one handshake per clock, with count=1 and inflight=1.
- Back-pressure: with m_ready=0, reads stop once count + inflight = BUF_DEPTH. At most BUF_DEPTH words are ever pulled ahead of the consumer.
- FIFO goes empty: fifo_rd_en drops in the same cycle. Buffered words continue to drain.
- Reset mid-operation:
  - the buffer is flushed, inflight is cleared, and fifo_data arriving the cycle after reset is discarded;
  - words already popped from the FIFO are lost by design;
  - fifo_rd_en is 0 for every cycle rst is high.
- fifo_rd_en is never asserted while fifo_empty=1.

## Structure
- Shared package fifo_pkg:
  - WIDTH default constant;
  - typedef word_t (logic [WIDTH-1:0]);
  - typedef cnt_t for word_cnt.
- Sub-module elastic_buf: a BUF_DEPTH-entry circular buffer.
  - Ports: push, push_data, pop, head_data, count.
  - Internally it uses wrapping read and write pointers and a count register; one entry is not reserved.
- The top level holds the credit logic, the inflight register and word_cnt.

## Test plan
- Reset: hold rst for 2 cycles with fifo_empty=0.
  - Required: fifo_rd_en=0, m_valid=0 and word_cnt=0 throughout.
  - Required: first fifo_rd_en=1 in the first cycle after rst drops.
- Streaming: FIFO preloaded with 1..8, m_ready=1.
  - Required: m_data = 1..8 on 8 consecutive cycles, the first two cycles after the first fifo_rd_en.
  - Required: word_cnt ends at 8.
- Back-pressure: FIFO holds 1..6, m_ready=0 for 10 cycles, then 1.
  - Required: exactly 3 fifo_rd_en pulses during the stall, and m_data stable at 1.
  - Required: after release, 1..6 delivered in order with no loss or duplicate.
- Alternating m_ready 1/0 with 5 words.
  - Required: 5 handshakes, in order.
  - Required: fifo_rd_en never high while fifo_empty=1.
  - Required: count never exceeds 3.
- Reset mid-stream: assert rst in the cycle after a fifo_rd_en.
  - Required: the next-cycle fifo_data is ignored, m_valid=0 and word_cnt=0.
  - Required: streaming resumes correctly after release.
- Counter wrap with CNT_W=4: 17 handshakes.
  - Required: word_cnt reads 15 after 15, 0 after 16, and 1 after 17.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared word and counter types for the FIFO and its read-side stream stage.
package fifo_pkg;
    localparam int WIDTH = 4;
    localparam int CNT_W = 16;
    typedef logic [WIDTH-1:0] word_t;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus valid/ready stream; master is the drain stage.
interface fifo_rd_stream_if #(
    parameter int WIDTH = fifo_pkg::WIDTH,
    parameter int CNT_W = fifo_pkg::CNT_W
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] word_cnt;
    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_data, m_valid, word_cnt
    );
    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_data, m_valid, word_cnt
    );
endinterface

// File: rtl/fifo_rd_stream_elastic_buf.sv
// elastic_buf: DEPTH-entry circular buffer with wrapping pointers; every entry is usable.
module elastic_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = fifo_pkg::WIDTH,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CW-1:0]    count_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    always_comb begin
        wr_d  = push_i ? (wr_q == LAST ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d  = pop_i ? (rd_q == LAST ? '0 : rd_q + PW'(1)) : rd_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) mem_q[wr_q] <= push_data_i;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign head_data_o = mem_q[rd_q];
    assign count_o     = cnt_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-read FIFO into a valid/ready stream at one word per clock.
// Reads are issued only against free buffer credit, so the read enable never depends on m_ready.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH     = fifo_pkg::WIDTH,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = fifo_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst,
    fifo_rd_stream_if.master bus
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head;
    logic             inflight_q, inflight_d, pop;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    always_comb begin
        pop        = bus.m_valid && bus.m_ready;
        inflight_d = !rst && !bus.fifo_empty && (({1'b0, count} + (CW + 1)'(inflight_q)) < DEPTH_C);
        word_cnt_d = pop ? word_cnt_q + CNT_W'(1) : word_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            word_cnt_q <= word_cnt_d;
        end
    end
    elastic_buf #(.WIDTH(WIDTH), .DEPTH(BUF_DEPTH), .CW(CW)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (bus.fifo_data),
        .pop_i       (pop),
        .head_data_o (head),
        .count_o     (count)
    );
    assign bus.fifo_rd_en = inflight_d;
    assign bus.m_valid    = count != '0;
    assign bus.m_data     = head;
    assign bus.word_cnt   = word_cnt_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench with a behavioural registered-read FIFO upstream.
module tb_fifo_rd_stream;
    import fifo_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fifo_rd_stream_if #(.WIDTH(WIDTH), .CNT_W(16)) bus ();
    fifo_rd_stream_if #(.WIDTH(WIDTH), .CNT_W(4))  bus4 ();
    fifo_rd_stream #(.WIDTH(WIDTH), .BUF_DEPTH(3), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    fifo_rd_stream #(.WIDTH(WIDTH), .BUF_DEPTH(3), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));
    word_t fifo_q[$], exp_q[$];
    word_t md;
    logic  rdy, rd, mv, hs;
    int    n_vec, n_err, exp_cnt, outst, rd_pulses, cyc, first_rd, first_hs, last_hs, n_left;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic tick();
        @(negedge clk);
        bus.fifo_empty  = fifo_q.size() == 0;
        bus4.fifo_empty = bus.fifo_empty;
        bus.m_ready     = rdy;
        bus4.m_ready    = rdy;
        #1;
        rd = bus.fifo_rd_en;
        mv = bus.m_valid;
        md = bus.m_data;
        hs = mv && rdy;
        chk("rd_while_empty", 32'(rd && bus.fifo_empty), 0);
        chk("rd_twin", 32'(bus4.fifo_rd_en), 32'(rd));
        chk("word_cnt", 32'(bus.word_cnt), 32'(exp_cnt[15:0]));
        chk("word_cnt4", 32'(bus4.word_cnt), 32'(exp_cnt[3:0]));
        if (rst) begin
            exp_q = fifo_q;
            chk("rd_in_rst", 32'(rd), 0);
        end else if (hs) begin
            if (exp_q.size() == 0) chk("unexpected_hs", 32'(exp_q.size()), 1);
            else chk("data", 32'(md), 32'(exp_q.pop_front()));
            exp_cnt++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end else if (mv && exp_q.size() > 0) chk("hold", 32'(md), 32'(exp_q[0]));
        if (rd) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
        end
        outst = rst ? 0 : outst + int'(rd) - int'(hs);
        chk("credit", 32'(outst <= 3), 1);
        @(posedge clk);
        #1;
        if (rst) exp_cnt = 0;
        if (rd) begin
            bus.fifo_data  = fifo_q.pop_front();
            bus4.fifo_data = bus.fifo_data;
        end
        cyc++;
    endtask
    task automatic load(input int n);
        for (int i = 1; i <= n; i++) fifo_q.push_back(word_t'(i));
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rd_pulses = 0;
        first_rd = -1;
        first_hs = -1;
    endtask
    task automatic run_until(input string tag, input int target, input int budget);
        int b = budget;
        while (exp_cnt < target && b > 0) begin
            tick();
            b--;
        end
        chk(tag, 32'(exp_cnt), 32'(target));
    endtask
    initial begin
        n_vec = 0; n_err = 0; exp_cnt = 0; outst = 0; cyc = 0;
        rd_pulses = 0; first_rd = -1; first_hs = -1; last_hs = -1;
        bus.fifo_data = '0;  bus4.fifo_data = '0;
        bus.fifo_empty = 1'b0; bus4.fifo_empty = 1'b0;
        rdy = 1'b1;
        bus.m_ready = 1'b1;  bus4.m_ready = 1'b1;
        load(8);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_rd_en", 32'(rd), 0);
            chk("rst_valid", 32'(mv), 0);
            chk("rst_cnt", 32'(bus.word_cnt), 0);
        end
        rst = 1'b0;
        first_rd = -1;
        first_hs = -1;
        tick();
        chk("first_rd_en", 32'(rd), 1);
        run_until("stream_done", 8, 30);
        chk("stream_latency", 32'(first_hs - first_rd), 2);
        chk("stream_b2b", 32'(last_hs - first_hs), 7);
        chk("stream_cnt", 32'(bus.word_cnt), 8);
        load(6);
        rdy = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("stall_rd_pulses", 32'(rd_pulses), 3);
        chk("stall_head", 32'(md), 1);
        chk("stall_valid", 32'(mv), 1);
        rdy = 1'b1;
        run_until("bp_done", 6, 30);
        chk("bp_no_leftover", 32'(exp_q.size()), 0);
        chk("bp_fifo_drained", 32'(fifo_q.size()), 0);
        load(5);
        do_reset();
        for (int i = 0; i < 40 && exp_cnt < 5; i++) begin
            rdy = ~rdy;
            tick();
        end
        chk("alt_cnt", 32'(bus.word_cnt), 5);
        chk("alt_fifo_drained", 32'(fifo_q.size()), 0);
        load(8);
        rdy = 1'b1;
        do_reset();
        run_until("pre_rst_words", 3, 20);
        chk("pre_rst_rd", 32'(rd), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_left = fifo_q.size();
        tick();
        chk("post_rst_valid", 32'(mv), 0);
        chk("post_rst_cnt", 32'(bus.word_cnt), 0);
        run_until("resume_done", n_left, 40);
        chk("resume_fifo_drained", 32'(fifo_q.size()), 0);
        load(17);
        rdy = 1'b1;
        do_reset();
        run_until("wrap_15", 15, 40);
        chk("wrap15", 32'(bus4.word_cnt), 15);
        run_until("wrap_16", 16, 5);
        chk("wrap16", 32'(bus4.word_cnt), 0);
        run_until("wrap_17", 17, 5);
        chk("wrap17", 32'(bus4.word_cnt), 1);
        chk("wide_cnt17", 32'(bus.word_cnt), 17);
        for (int i = 0; i < 3; i++) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
